// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: round-robin write arbiter and read sequencer in front of fifo_sync, issuing one FIFO op per cycle.
// Define FIFO_SYNC_CTRL_CHECK_EN to compile the sticky flag-consistency checker driving err.
module fifo_sync_ctrl #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic                             rd_req,
   output logic                             rd_valid,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             fifo_cs,
   output logic                             fifo_wr_en,
   output logic                             fifo_rd_en,
   output logic [DATA_WIDTH-1:0]            fifo_data_in,
   input  logic [DATA_WIDTH-1:0]            fifo_data_out,
   input  logic                             fifo_full,
   input  logic                             fifo_empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic                             err
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_e;

   op_e                   op;
   op_e                   last_op_q, last_op_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                  rd_pend_q, rd_pend_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic [PTR_W-1:0]      winner;
   logic                  found;
   logic                  wr_cand, rd_cand;

   // First valid requester at or above rr_ptr, wrapping back to 0.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] cand;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = PTR_W'(idx);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      wr_cand = (|req_valid) && (count_q < DEPTH_C);
      rd_cand = rd_req && (count_q != '0);
      op      = OP_IDLE;
      if (rst)
         op = OP_IDLE;
      else if (wr_cand && rd_cand)
         op = (last_op_q == OP_READ) ? OP_WRITE : OP_READ;
      else if (wr_cand)
         op = OP_WRITE;
      else if (rd_cand)
         op = OP_READ;
   end

   always_comb begin
      fifo_cs    = 1'b0;
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
      req_ready  = '0;
      count_d    = count_q;
      rr_ptr_d   = rr_ptr_q;
      last_op_d  = last_op_q;
      rd_pend_d  = 1'b0;
      data_in_d  = data_in_q;
      case (op)
         OP_WRITE: begin
            fifo_cs           = 1'b1;
            fifo_wr_en        = 1'b1;
            req_ready[winner] = 1'b1;
            data_in_d         = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
            count_d           = count_q + CNT_W'(1);
            rr_ptr_d          = (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
            last_op_d         = OP_WRITE;
         end
         OP_READ: begin
            fifo_cs    = 1'b1;
            fifo_rd_en = 1'b1;
            count_d    = count_q - CNT_W'(1);
            last_op_d  = OP_READ;
            rd_pend_d  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         rr_ptr_q  <= '0;
         last_op_q <= OP_READ;
         rd_pend_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         rr_ptr_q  <= rr_ptr_d;
         last_op_q <= last_op_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // Idle cycles keep presenting the last written word.
   always_ff @(posedge clk) begin
      data_in_q <= data_in_d;
   end

   assign fifo_data_in = data_in_d;
   assign rd_valid     = rd_pend_q;
   assign rd_data      = fifo_data_out;
   assign count        = count_q;

`ifdef FIFO_SYNC_CTRL_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((fifo_full != (count_q == DEPTH_C)) || (fifo_empty != (count_q == '0)))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`else
   logic unused_flags;
   assign unused_flags = fifo_full ^ fifo_empty;
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Bench for fifo_sync_ctrl: behavioural FIFO model plus a read-data scoreboard checked on every rd_valid pulse.
module tb_fifo_sync_ctrl;
   localparam int NUM_REQ = 4;
   localparam int DW      = 32;
   localparam int DEPTH   = 8;
   localparam int CW      = $clog2(DEPTH + 1);

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ*DW-1:0] req_data = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  rd_req = 1'b0;
   logic                  rd_valid;
   logic [DW-1:0]         rd_data;
   logic                  fifo_cs, fifo_wr_en, fifo_rd_en;
   logic [DW-1:0]         fifo_data_in;
   logic [DW-1:0]         fifo_data_out = '0;
   logic                  fifo_full, fifo_empty;
   logic [CW-1:0]         count;
   logic                  err;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mem_q[$];
   int            mem_cnt = 0;
   logic          force_empty_low = 1'b0;

   fifo_sync_ctrl #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
      .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .count(count), .err(err)
   );

   always #5 clk = ~clk;

   // Behavioural fifo_sync: registered read data, flags from its own occupancy.
   always @(posedge clk) begin
      if (rst) begin
         mem_q.delete();
         mem_cnt <= 0;
      end else if (fifo_cs && fifo_wr_en) begin
         mem_q.push_back(fifo_data_in);
         mem_cnt <= mem_cnt + 1;
      end else if (fifo_cs && fifo_rd_en && mem_q.size() > 0) begin
         fifo_data_out <= mem_q.pop_front();
         mem_cnt <= mem_cnt - 1;
      end
   end

   assign fifo_full  = (mem_cnt == DEPTH);
   assign fifo_empty = force_empty_low ? 1'b0 : (mem_cnt == 0);

   always @(negedge clk) begin
      logic [DW-1:0] exp;
      if (rd_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: rd_valid=1 data=%h, required no read", rd_data);
         end else begin
            exp = exp_q.pop_front();
            if (rd_data !== exp) begin
               errors++;
               $display("FAIL rd_data: got %h, expected %h", rd_data, exp);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain(input int n);
      @(negedge clk);
      req_valid = '0; rd_req = 1'b1;
      repeat (n) @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '1; rd_req = 1'b1;
      #1;
      checks++;
      if ({fifo_cs, fifo_wr_en, fifo_rd_en} !== 3'b000 || req_ready !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: cs/wr/rd=%b ready=%b, expected 000/0000",
                  {fifo_cs, fifo_wr_en, fifo_rd_en}, req_ready);
      end
      @(negedge clk);
      checks++;
      if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", count); end
      checks++;
      if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b, expected 0", rd_valid); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", err); end
      rst = 1'b0; req_valid = '0;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en: got %b, expected 0", fifo_rd_en); end
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic test_single_writer();
      logic [NUM_REQ-1:0] exp_rdy;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         req_valid = 4'b0100;
         req_data[2*DW +: DW] = 32'h10 + c;
         #1;
         exp_rdy = (c < 8) ? 4'b0100 : 4'b0000;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL single_ready[%0d]: got %b, expected %b", c, req_ready, exp_rdy);
         end
         if (c < 8) begin
            checks++;
            if (fifo_data_in !== 32'h10 + c) begin
               errors++;
               $display("FAIL single_data_in[%0d]: got %h, expected %h", c, fifo_data_in, 32'h10 + c);
            end
            exp_q.push_back(32'h10 + c);
         end
      end
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (count !== CW'(8)) begin errors++; $display("FAIL single_count: got %0d, expected 8", count); end
      drain(8);
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] exp_rdy;
      int gcnt[NUM_REQ];
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         req_valid = '1;
         for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = (c << 8) | i;
         #1;
         exp_rdy = (c < 8) ? NUM_REQ'(1 << (c % NUM_REQ)) : '0;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got %b, expected %b", c, req_ready, exp_rdy);
         end
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i] === 1'b1) gcnt[i]++;
         if (c < 8) exp_q.push_back((c << 8) | (c % NUM_REQ));
      end
      @(negedge clk);
      req_valid = '0;
      checks++;
      if (count !== CW'(8)) begin errors++; $display("FAIL rr_count: got %0d, expected 8", count); end
      for (int i = 0; i < NUM_REQ; i++) begin
         checks++;
         if (gcnt[i] != 2) begin errors++; $display("FAIL rr_grants_req%0d: got %0d, expected 2", i, gcnt[i]); end
      end
      drain(8);
   endtask

   task automatic test_read_stream();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_valid = 4'b0001;
         req_data[0 +: DW] = 32'hA0 + c;
         exp_q.push_back(32'hA0 + c);
      end
      @(negedge clk);
      req_valid = '0; rd_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (rd_valid !== (c < 4)) begin
            errors++;
            $display("FAIL stream_rd_valid[%0d]: got %b, expected %b", c, rd_valid, (c < 4));
         end
      end
      rd_req = 1'b0;
      checks++;
      if (count !== '0) begin errors++; $display("FAIL stream_count: got %0d, expected 0", count); end
   endtask

   task automatic test_contention();
      logic [CW-1:0] exp_cnt;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = 4'b0001;
         req_data[0 +: DW] = 32'hB0 + c;
         exp_q.push_back(32'hB0 + c);
      end
      @(negedge clk);
      req_valid = '0; rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      checks++;
      if (count !== CW'(4)) begin errors++; $display("FAIL cont_start_count: got %0d, expected 4", count); end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c > 0) begin
            exp_cnt = ((c - 1) % 2 == 0) ? CW'(5) : CW'(4);
            checks++;
            if (count !== exp_cnt) begin
               errors++;
               $display("FAIL cont_count[%0d]: got %0d, expected %0d", c, count, exp_cnt);
            end
         end
         req_valid = 4'b0010; rd_req = 1'b1;
         req_data[1*DW +: DW] = 32'hC0 + c;
         #1;
         checks++;
         if (fifo_wr_en !== (c % 2 == 0) || fifo_rd_en !== (c % 2 == 1) || (fifo_wr_en && fifo_rd_en)) begin
            errors++;
            $display("FAIL cont_op[%0d]: wr_en=%b rd_en=%b, expected wr_en=%b rd_en=%b",
                     c, fifo_wr_en, fifo_rd_en, (c % 2 == 0), (c % 2 == 1));
         end
         if (c % 2 == 0) exp_q.push_back(32'hC0 + c);
      end
      @(negedge clk);
      req_valid = '0; rd_req = 1'b0;
      checks++;
      if (count !== CW'(4)) begin errors++; $display("FAIL cont_end_count: got %0d, expected 4", count); end
      drain(4);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL cont_err: got %b, expected 0", err); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_valid = 4'b0010;
         req_data[1*DW +: DW] = 32'hD0 + c;
      end
      @(negedge clk);
      rst = 1'b1; req_valid = '1; rd_req = 1'b1;
      #1;
      checks++;
      if ({fifo_cs, fifo_wr_en, fifo_rd_en} !== 3'b000 || req_ready !== '0) begin
         errors++;
         $display("FAIL midrst_ctrl: cs/wr/rd=%b ready=%b, expected 000/0000",
                  {fifo_cs, fifo_wr_en, fifo_rd_en}, req_ready);
      end
      @(negedge clk);
      rst = 1'b0; req_valid = '0;
      exp_q.delete();
      checks++;
      if (count !== '0) begin errors++; $display("FAIL midrst_count: got %0d, expected 0", count); end
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en[%0d]: got %b, expected 0", c, fifo_rd_en); end
         @(negedge clk);
         checks++;
         if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid[%0d]: got %b, expected 0", c, rd_valid); end
      end
      rd_req = 1'b0;
      req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = 32'hE0 + i;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_rr_ptr: got %b, expected 0001", req_ready); end
      exp_q.push_back(32'hE0);
      @(negedge clk);
      req_valid = '0;
      drain(1);
   endtask

   task automatic test_checker();
      do_reset();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL chk_initial: got %b, expected 0", err); end
      @(negedge clk);
      force_empty_low = 1'b1;
      @(negedge clk);
      force_empty_low = 1'b0;
`ifdef FIFO_SYNC_CTRL_CHECK_EN
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL chk_set: got %b, expected 1", err); end
      repeat (3) @(negedge clk);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL chk_sticky: got %b, expected 1", err); end
      do_reset();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL chk_clear: got %b, expected 0", err); end
`else
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL chk_disabled: got %b, expected 0", err); end
`endif
   endtask

   initial begin
      test_reset();
      test_single_writer();
      test_round_robin();
      test_read_stream();
      test_contention();
      test_reset_midop();
      test_checker();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d words, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_sync_ctrl.md
# fifo_sync_ctrl

Front-end controller for the `fifo_sync` buffer. It shares the single FIFO write port among `NUM_REQ` producers using round-robin arbitration and serves one consumer's read requests. It sequences the FIFO's shared `cs`/`wr_en`/`rd_en` controls so that exactly one operation is issued per cycle. It keeps its own occupancy count, so grants never depend on flag timing.

## Interface
- `NUM_REQ`, 4: number of write requesters, 2..8.
- `DATA_WIDTH`, 32: word width; must match the FIFO.
- `FIFO_DEPTH`, 8: FIFO capacity in words; must match the FIFO.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in NUM_REQ: per-requester write request.
- `req_data` in NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: one-hot grant; a write transfer occurs when `req_valid[i] & req_ready[i]`.
- `rd_req` in 1: consumer requests one word (level; one word per granted cycle).
- `rd_valid` out 1: one-cycle pulse; `rd_data` holds a popped word.
- `rd_data` out DATA_WIDTH: equals `fifo_data_out`.
- `fifo_cs`, `fifo_wr_en`, `fifo_rd_en` out 1 each: FIFO controls.
- `fifo_data_in` out DATA_WIDTH: granted requester's data.
- `fifo_data_out` in DATA_WIDTH: FIFO read data, registered one cycle after the read is issued.
- `fifo_full`, `fifo_empty` in 1: FIFO flags, used only by the consistency checker.
- `count` out $clog2(FIFO_DEPTH+1): words currently held.
- `err` out 1: sticky flag-mismatch error.

## Operation
- Each cycle, one of three operations is chosen combinationally: WRITE, READ or IDLE.
- A write candidate exists when any `req_valid` is set and `count < FIFO_DEPTH`.
- A read candidate exists when `rd_req` is set and `count > 0`.
- Only one candidate: it is issued.
- Both candidates: the operation opposite to `last_op` is issued, so read and write alternate under contention.
- Neither candidate: IDLE. `fifo_cs` = `fifo_wr_en` = `fifo_rd_en` = 0 and `req_ready` = 0.
- WRITE:
  - `fifo_cs` = 1, `fifo_wr_en` = 1, `fifo_rd_en` = 0.
  - The winner is the first requester with `req_valid` set, searching upward from `rr_ptr` with wrap at NUM_REQ-1 → 0.
  - `req_ready` is one-hot at the winner; `fifo_data_in` carries the winner's data.
  - At the clock edge: `rr_ptr` ← winner+1 (mod NUM_REQ), `count` +1, `last_op` ← WRITE.
- READ:
  - `fifo_cs` = 1, `fifo_rd_en` = 1, `fifo_wr_en` = 0.
  - At the clock edge: `count` −1, `last_op` ← READ, `rd_pend` ← 1.
- `rd_valid` = `rd_pend`. It is high exactly in the cycle after a READ is issued; `rd_data` = `fifo_data_out` in that cycle.
- No simultaneous read and write is ever issued, so `count` changes by at most 1 per cycle.
- When IDLE, `fifo_data_in` holds the value last driven; it is a don't-care to the FIFO.

## Timing
- Reset values: `count` = 0, `rr_ptr` = 0, `last_op` = READ (the first contention favours the write), `rd_pend` = 0, `rd_valid` = 0, `err` = 0.
  - All combinational FIFO controls are 0 while `rst` is high.
- Reset asserted mid-operation: any operation in flight that cycle is suppressed. The FIFO is reset alongside, so the counts agree afterwards.
- Write latency: 0. The word is committed at the edge ending the granted cycle.
- Read latency: 1. Data is valid in the cycle following issue.
- Full: at `count` = FIFO_DEPTH, no `req_ready` is asserted, and a READ is issued if `rd_req` is set.
- Empty: at `count` = 0, `rd_req` is ignored and `rd_valid` stays 0.
- `rd_req` held high with `count` = k and no writers: exactly k `rd_valid` pulses in k consecutive cycles, the first one cycle after `rd_req` rises.

## Configuration
- `FIFO_SYNC_CTRL_CHECK_EN` defined:
  - Each cycle after reset, `fifo_full` is compared with (`count` == FIFO_DEPTH) and `fifo_empty` with (`count` == 0).
  - Any mismatch sets `err`, which holds until `rst`.
- `FIFO_SYNC_CTRL_CHECK_EN` undefined:
  - The checker is not compiled; `err` is tied to 0.
  - `fifo_full` and `fifo_empty` are unused.

## Test plan
- Reset, then requester 2 alone writes 8 words 0x10..0x17 → one grant per cycle, `count` reaches 8, `req_ready` = 0 on the 9th cycle with `req_valid[2]` still high.
- All 4 requesters valid with FIFO empty and no reads → grant order 0,1,2,3,0,1,2,3; after 8 cycles `count` = 8, with each requester granted twice.
- FIFO holds 0xA0..0xA3, `rd_req` held high → `rd_valid` pulses on 4 consecutive cycles with data 0xA0, 0xA1, 0xA2, 0xA3; then `rd_valid` = 0 and `count` = 0.
- `count` = 4, requester 1 and `rd_req` both continuously active → operations alternate W,R,W,R starting with W after reset. `count` oscillates between 5 and 4 and `fifo_wr_en` & `fifo_rd_en` are never both 1.
- Assert `rst` for 1 cycle while writes are pending at `count` = 6 → `count` = 0, `rr_ptr` = 0, no FIFO control is asserted in the reset cycle, and a subsequent read request with no writes yields no `rd_valid`.
- With `FIFO_SYNC_CTRL_CHECK_EN` defined, force `fifo_empty` = 0 while `count` = 0 → `err` = 1 on the next cycle and it stays 1 until `rst`.
